// File: rtl/coin_gen.sv
// Coin sprite layer: holds the coin position, detects pickups once per frame,
// runs the collect/blink/respawn FSM and drives a registered yellow pixel.
module coin_gen #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned COIN_SIZE      = 16,
  parameter int unsigned CHAR_SIZE      = 16,
  parameter int unsigned INIT_X         = 312,
  parameter int unsigned INIT_Y         = 232,
  parameter int unsigned BLINK_FRAMES   = 16,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic [9:0] char_x,
  input  logic [9:0] char_y,
  output logic       r_coin,
  output logic       g_coin,
  output logic       b_coin,
  output logic [9:0] coin_x,
  output logic [9:0] coin_y,
  output logic [7:0] coin_count,
  output logic       collect_pulse
);

  localparam int unsigned CW   = 10;
  localparam int unsigned NW   = 8;
  localparam int unsigned FMAX = (BLINK_FRAMES > RESPAWN_FRAMES) ? BLINK_FRAMES : RESPAWN_FRAMES;
  localparam int unsigned FW   = (FMAX > 4) ? $clog2(FMAX) : 2;

  localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - COIN_SIZE);
  localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - COIN_SIZE);
  localparam logic [15:0]   SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_BLINK,
    ST_HIDDEN
  } state_t;

  state_t          state, state_nx;
  logic [FW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   x_nx, y_nx;
  logic [NW-1:0]   count_nx;
  logic            pulse_nx;
  logic [15:0]     lfsr;
  logic            lfsr_fb;
  logic [CW-1:0]   cand_x, cand_y, raw_y;
  logic            hit, cand_hit, visible;
  logic            in_box, corner, pixel_on;
  logic [CW-1:0]   off_x, off_y;

  // Strict overlap of a COIN_SIZE box at (ax,ay) with a CHAR_SIZE box at (bx,by).
  function automatic logic boxes_overlap(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                         input logic [CW-1:0] bx, input logic [CW-1:0] by);
    logic [CW:0] axe, aye, bxe, bye;
    axe = {1'b0, ax};
    aye = {1'b0, ay};
    bxe = {1'b0, bx};
    bye = {1'b0, by};
    boxes_overlap = (axe < bxe + (CW+1)'(CHAR_SIZE)) && (bxe < axe + (CW+1)'(COIN_SIZE)) &&
                    (aye < bye + (CW+1)'(CHAR_SIZE)) && (bye < aye + (CW+1)'(COIN_SIZE));
  endfunction

  function automatic logic is_edge(input logic [CW-1:0] off);
    is_edge = (off < CW'(2)) || (off >= CW'(COIN_SIZE - 2));
  endfunction

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Respawn candidate folded back into the visible range.
  always_comb begin
    raw_y    = {1'b0, lfsr[15:7]};
    cand_x   = (lfsr[9:0] > X_MAX) ? (lfsr[9:0] - X_MAX) : lfsr[9:0];
    cand_y   = (raw_y > Y_MAX) ? (raw_y - Y_MAX) : raw_y;
    hit      = boxes_overlap(coin_x, coin_y, char_x, char_y);
    cand_hit = boxes_overlap(cand_x, cand_y, char_x, char_y);
  end

  always_comb begin
    visible = 1'b0;
    unique case (state)
      ST_ACTIVE: visible = 1'b1;
      ST_BLINK:  visible = cnt[1];
      ST_HIDDEN: visible = 1'b0;
      default:   visible = 1'b0;
    endcase
  end

  // Pixel hit test against the current (pre-update) coin position.
  always_comb begin
    off_x    = hcount - coin_x;
    off_y    = vcount - coin_y;
    in_box   = ({1'b0, hcount} >= {1'b0, coin_x}) &&
               ({1'b0, hcount} <  {1'b0, coin_x} + (CW+1)'(COIN_SIZE)) &&
               ({1'b0, vcount} >= {1'b0, coin_y}) &&
               ({1'b0, vcount} <  {1'b0, coin_y} + (CW+1)'(COIN_SIZE));
    corner   = is_edge(off_x) && is_edge(off_y);
    pixel_on = video_on && in_box && !corner && visible;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = coin_x;
    y_nx     = coin_y;
    count_nx = coin_count;
    pulse_nx = 1'b0;
    if (frame_start) begin
      unique case (state)
        ST_ACTIVE: begin
          if (hit) begin
            state_nx = ST_BLINK;
            cnt_nx   = '0;
            pulse_nx = 1'b1;
            if (coin_count != '1) count_nx = coin_count + NW'(1);
          end
        end
        ST_BLINK: begin
          if (cnt == FW'(BLINK_FRAMES - 1)) begin
            state_nx = ST_HIDDEN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + FW'(1);
          end
        end
        ST_HIDDEN: begin
          // Counter parks at the last value while a blocked candidate retries.
          if (cnt == FW'(RESPAWN_FRAMES - 1)) begin
            if (!cand_hit) begin
              state_nx = ST_ACTIVE;
              cnt_nx   = '0;
              x_nx     = cand_x;
              y_nx     = cand_y;
            end
          end else begin
            cnt_nx = cnt + FW'(1);
          end
        end
        default: begin
          state_nx = ST_ACTIVE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_ACTIVE;
      cnt           <= '0;
      coin_x        <= CW'(INIT_X);
      coin_y        <= CW'(INIT_Y);
      coin_count    <= '0;
      collect_pulse <= 1'b0;
      lfsr          <= SEED;
      r_coin        <= 1'b0;
      g_coin        <= 1'b0;
      b_coin        <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      coin_x        <= x_nx;
      coin_y        <= y_nx;
      coin_count    <= count_nx;
      collect_pulse <= pulse_nx;
      if (pix_en) begin
        lfsr   <= {lfsr[14:0], lfsr_fb};
        r_coin <= pixel_on;
        g_coin <= pixel_on;
        b_coin <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coin_gen.sv
// Directed bench for coin_gen: pixel window, blink cadence, edge-touch pickups,
// seeded respawn with retry, count saturation and asynchronous reset.
module tb_coin_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       video_on = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] char_x = '0;
  logic [9:0] char_y = '0;
  logic       r_coin, g_coin, b_coin;
  logic [9:0] coin_x, coin_y;
  logic [7:0] coin_count;
  logic       collect_pulse;

  int errors = 0;
  int checks = 0;

  // Seed 0xFA7F: lfsr[9:0]=639 -> x=15, lfsr[15:7]=500 -> y=36.
  coin_gen #(.LFSR_SEED(16'hFA7F)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .frame_start(frame_start), .char_x(char_x), .char_y(char_y),
    .r_coin(r_coin), .g_coin(g_coin), .b_coin(b_coin), .coin_x(coin_x), .coin_y(coin_y),
    .coin_count(coin_count), .collect_pulse(collect_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic von);
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = von;
    pix_en   = 1'b1;
    tick();
    pix_en   = 1'b0;
  endtask

  task automatic fs(output logic p);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    p = collect_pulse;
    tick();
  endtask

  task automatic fs_n(input int n);
    logic p;
    for (int i = 0; i < n; i++) fs(p);
  endtask

  task automatic set_char(input int x, input int y);
    char_x = 10'(x);
    char_y = 10'(y);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic        p;
    int          lit, minh, maxh, minv, maxv, gbad, bbad;
    logic [15:0] blink_exp;
    blink_exp = 16'hCCCC;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_coin_x", coin_x, 312);
    check("rst_coin_y", coin_y, 232);
    check("rst_count", coin_count, 0);
    check("rst_pulse", collect_pulse, 0);
    check("rst_rgb", {r_coin, g_coin, b_coin}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pixel window sweep with the character parked at (0,0)
    set_char(0, 0);
    lit = 0; minh = 1023; maxh = 0; minv = 1023; maxv = 0; gbad = 0; bbad = 0;
    for (int v = 228; v < 252; v++) begin
      for (int h = 308; h < 332; h++) begin
        pix(h, v, 1'b1);
        if (r_coin) begin
          lit++;
          if (h < minh) minh = h;
          if (h > maxh) maxh = h;
          if (v < minv) minv = v;
          if (v > maxv) maxv = v;
        end
        if (g_coin !== r_coin) gbad++;
        if (b_coin !== 1'b0) bbad++;
      end
    end
    check("sweep_lit", lit, 240);
    check("sweep_minh", minh, 312);
    check("sweep_maxh", maxh, 327);
    check("sweep_minv", minv, 232);
    check("sweep_maxv", maxv, 247);
    check("sweep_green", gbad, 0);
    check("sweep_blue", bbad, 0);
    check("sweep_count", coin_count, 0);

    // Corners and video_on gating
    pix(312, 232, 1'b1); check("corner_tl", r_coin, 0);
    pix(313, 233, 1'b1); check("corner_tl_in", r_coin, 0);
    pix(314, 233, 1'b1); check("edge_2_1", r_coin, 1);
    pix(312, 247, 1'b1); check("corner_bl", r_coin, 0);
    pix(326, 247, 1'b1); check("corner_br", r_coin, 0);
    pix(325, 247, 1'b1); check("edge_13_15", r_coin, 1);
    pix(320, 240, 1'b0); check("video_off", r_coin, 0);

    // One-clock latency and hold between enables
    pix(0, 0, 1'b1);
    hcount = 10'd314; vcount = 10'd240; video_on = 1'b1; pix_en = 1'b1;
    #2;
    check("latency_before", r_coin, 0);
    tick();
    check("latency_after", r_coin, 1);
    pix_en = 1'b0;
    hcount = 10'd0;
    tick();
    check("hold_no_en", r_coin, 1);

    // Pickup and blink cadence
    set_char(320, 240);
    fs(p);
    check("pickup_pulse", p, 1);
    check("pulse_one_clk", collect_pulse, 0);
    check("pickup_count", coin_count, 1);
    for (int f = 0; f < 16; f++) begin
      pix(320, 240, 1'b1);
      check($sformatf("blink_f%0d", f), r_coin, blink_exp[f]);
      fs(p);
    end
    pix(320, 240, 1'b1);
    check("hidden_dark", r_coin, 0);
    check("blink_no_rescore", coin_count, 1);

    // Edge-touch collisions, seeded respawn (no pix_en, lfsr stays at seed)
    do_reset();
    set_char(328, 240); fs(p); check("touch_x", p, 0);
    set_char(320, 216); fs(p); check("touch_y", p, 0);
    set_char(327, 240); fs(p); check("overlap_x327", p, 1);
    check("overlap_count", coin_count, 1);
    set_char(320, 240);
    fs_n(45);
    check("pre_respawn_x", coin_x, 312);
    check("no_rescore_hidden", coin_count, 1);
    fs(p);
    check("respawn_x", coin_x, 15);
    check("respawn_y", coin_y, 36);

    // Blocked candidate: retries without respawning
    set_char(20, 40); fs(p); check("second_pickup", p, 1);
    check("second_count", coin_count, 2);
    fs_n(48);
    check("retry_still_hidden", coin_count, 2);
    set_char(320, 240); fs(p); check("retry_respawn_no_pulse", p, 0);
    set_char(20, 40); fs(p); check("after_retry_active", p, 1);
    check("third_count", coin_count, 3);

    // Drive the count to saturation
    set_char(320, 240);
    fs_n(46);
    for (int k = 0; k < 252; k++) begin
      set_char(20, 40);
      fs(p);
      set_char(320, 240);
      fs_n(46);
    end
    check("count_255", coin_count, 255);

    // Saturated pickup coinciding with a pixel enable
    set_char(20, 40);
    hcount = 10'd20; vcount = 10'd40; video_on = 1'b1;
    frame_start = 1'b1; pix_en = 1'b1;
    tick();
    frame_start = 1'b0; pix_en = 1'b0;
    check("sat_pulse", collect_pulse, 1);
    check("sat_count", coin_count, 255);
    check("pre_update_pixel", r_coin, 1);
    pix(20, 40, 1'b1); check("blink_cnt0_dark", r_coin, 0);
    fs_n(2);
    pix(20, 40, 1'b1); check("blink_cnt2_lit", r_coin, 1);
    fs(p);

    // Asynchronous reset mid-blink
    #2 rst_n = 1'b0;
    #1;
    check("arst_rgb", {r_coin, g_coin, b_coin}, 0);
    check("arst_x", coin_x, 312);
    check("arst_y", coin_y, 232);
    check("arst_count", coin_count, 0);
    check("arst_pulse", collect_pulse, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pix(314, 240, 1'b1);
    check("arst_state_active", r_coin, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
